axis_fifo_traffic_gen_chk: RTL and testbench

- Synthesizable AXI-Stream traffic generator and checker for on-board self-test of ddr3_rw_controller.
- Drives the controller's write port (s_axis_*) as an AXIS master with a 16-bit LFSR sequence.
- Consumes the controller's read port (m_axis_*) as an AXIS slave and checks every word against an identical LFSR.
- Reports done, pass, error count, and first-error index; sits between board-level start/LED logic and the FIFO wrapper.

---
 rtl/axis_fifo_traffic_gen_chk.sv | 270 +++++++++++++++++++++++++++
 tb/tb_axis_fifo_traffic_gen_chk.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_traffic_gen_chk.sv
// -----------------------------------------------------------------------------
// axis_fifo_traffic_gen_chk
//
// Purpose:
//   AXI-Stream traffic generator and checker for on-board self-test of the
//   DDR3 FIFO controller.
//   - Write side (AXIS master) emits a 16-bit Fibonacci LFSR sequence
//     (x^16+x^14+x^13+x^11+1).
//   - Read side (AXIS slave) checks every returned word against an
//     independent copy of the same LFSR.
//   - Reports done/pass, a saturating error count, the index of the first
//     mismatch and the number of beats accepted on each side.
//
// Ports:
//   clk            single clock for both stream sides
//   rst_n          asynchronous active-low reset
//   start          single-cycle start pulse (ignored while busy)
//   num_words      words to write and read, sampled when start is accepted
//   m_axis_tvaild  write-stream valid   (to controller s_axis_tvaild)
//   m_axis_tready  write-stream ready   (from controller s_axis_tready)
//   m_axis_tdata   write-stream data
//   s_axis_tvaild  read-stream valid    (from controller m_axis_tvaild)
//   s_axis_tready  read-stream ready    (to controller m_axis_tready)
//   s_axis_tdata   read-stream data
//   busy           high while the test is running
//   done           test finished, held until the next start
//   pass           meaningful when done=1: no errors, counts complete
//   timeout        test aborted because no beat was seen for too long
//   err_cnt        mismatch count, saturating at 16'hFFFF
//   first_err_idx  read index of the first mismatch, all-ones if none
//   wr_cnt         write beats accepted
//   rd_cnt         read beats accepted
//
// Build option:
//   AXIS_TRAFFIC_BACKPRESSURE_EN - when defined, a free-running LFSR
//   (seed 16'h1D0F) throttles the read-side ready and inserts idle cycles
//   on the write side after some beats. Undefined: full-rate traffic.
// -----------------------------------------------------------------------------
module axis_fifo_traffic_gen_chk #(
    parameter logic [15:0] SEED           = 16'hACE1,
    parameter int          CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_words,
    output logic             m_axis_tvaild,
    input  logic             m_axis_tready,
    output logic [15:0]      m_axis_tdata,
    input  logic             s_axis_tvaild,
    output logic             s_axis_tready,
    input  logic [15:0]      s_axis_tdata,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [15:0]      err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] rd_cnt
);

    // A zero seed would lock the LFSR, so it is replaced by the default.
    localparam logic [15:0]      SEED_EFF    = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [31:0]      TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ALL_ONES    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ZERO_CNT    = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Fibonacci LFSR step, taps 16/14/13/11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        lfsr_next = {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] num_words_r;
    logic [CNT_W-1:0] wr_cnt_r;
    logic [CNT_W-1:0] rd_cnt_r;
    logic [15:0]      err_cnt_r;
    logic [CNT_W-1:0] first_err_idx_r;
    logic [15:0]      gen_lfsr_r;
    logic [15:0]      chk_lfsr_r;
    logic [31:0]      idle_cnt_r;
    logic             done_r;
    logic             pass_r;
    logic             timeout_r;

    logic             start_acc_s;
    logic             wr_more_s;
    logic             rd_more_s;
    logic             m_vld_s;
    logic             s_rdy_s;
    logic             wr_beat_s;
    logic             rd_beat_s;
    logic             any_beat_s;
    logic             mismatch_s;
    logic [CNT_W-1:0] wr_cnt_nx_s;
    logic [CNT_W-1:0] rd_cnt_nx_s;
    logic [15:0]      err_cnt_nx_s;
    logic [31:0]      idle_inc_s;
    logic             complete_s;
    logic             timeout_s;

`ifdef AXIS_TRAFFIC_BACKPRESSURE_EN
    localparam logic [15:0] BP_SEED = 16'h1D0F;
    logic [15:0] bp_lfsr_r;
    logic        gap_r;
`endif

    // Handshake qualifiers, beat detection and next-value arithmetic.
    always_comb begin
        start_acc_s = start && (state_r != ST_RUN);
        wr_more_s   = (wr_cnt_r < num_words_r);
        rd_more_s   = (rd_cnt_r < num_words_r);
`ifdef AXIS_TRAFFIC_BACKPRESSURE_EN
        // The gap cycle only follows a completed beat, so valid is never
        // withdrawn while a transfer is pending.
        m_vld_s = (state_r == ST_RUN) && wr_more_s && !gap_r;
        s_rdy_s = (state_r == ST_RUN) && rd_more_s && bp_lfsr_r[0];
`else
        m_vld_s = (state_r == ST_RUN) && wr_more_s;
        s_rdy_s = (state_r == ST_RUN) && rd_more_s;
`endif
        wr_beat_s   = m_vld_s && m_axis_tready;
        rd_beat_s   = s_rdy_s && s_axis_tvaild;
        any_beat_s  = wr_beat_s || rd_beat_s;
        mismatch_s  = rd_beat_s && (s_axis_tdata != chk_lfsr_r);
        wr_cnt_nx_s = wr_cnt_r + {{(CNT_W-1){1'b0}}, wr_beat_s};
        rd_cnt_nx_s = rd_cnt_r + {{(CNT_W-1){1'b0}}, rd_beat_s};
        if (mismatch_s && (err_cnt_r != 16'hFFFF)) begin
            err_cnt_nx_s = err_cnt_r + 16'd1;
        end else begin
            err_cnt_nx_s = err_cnt_r;
        end
        complete_s = (wr_cnt_nx_s == num_words_r) && (rd_cnt_nx_s == num_words_r);
        idle_inc_s = idle_cnt_r + 32'd1;
        timeout_s  = (TIMEOUT_LIM != 32'd0) && !any_beat_s && (idle_inc_s >= TIMEOUT_LIM);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_acc_s) begin
                    if (num_words == ZERO_CNT) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (complete_s || timeout_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Counters, LFSRs and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_words_r     <= ZERO_CNT;
            wr_cnt_r        <= ZERO_CNT;
            rd_cnt_r        <= ZERO_CNT;
            err_cnt_r       <= 16'h0000;
            first_err_idx_r <= ALL_ONES;
            gen_lfsr_r      <= SEED_EFF;
            chk_lfsr_r      <= SEED_EFF;
            idle_cnt_r      <= 32'd0;
            done_r          <= 1'b0;
            pass_r          <= 1'b0;
            timeout_r       <= 1'b0;
        end else if (start_acc_s) begin
            num_words_r     <= num_words;
            wr_cnt_r        <= ZERO_CNT;
            rd_cnt_r        <= ZERO_CNT;
            err_cnt_r       <= 16'h0000;
            first_err_idx_r <= ALL_ONES;
            gen_lfsr_r      <= SEED_EFF;
            chk_lfsr_r      <= SEED_EFF;
            idle_cnt_r      <= 32'd0;
            timeout_r       <= 1'b0;
            // A zero-length test completes immediately and trivially passes.
            done_r          <= (num_words == ZERO_CNT);
            pass_r          <= (num_words == ZERO_CNT);
        end else if (state_r == ST_RUN) begin
            wr_cnt_r   <= wr_cnt_nx_s;
            rd_cnt_r   <= rd_cnt_nx_s;
            err_cnt_r  <= err_cnt_nx_s;
            idle_cnt_r <= any_beat_s ? 32'd0 : idle_inc_s;
            if (mismatch_s && (first_err_idx_r == ALL_ONES)) begin
                first_err_idx_r <= rd_cnt_r;
            end
            if (wr_beat_s) begin
                gen_lfsr_r <= lfsr_next(gen_lfsr_r);
            end
            if (rd_beat_s) begin
                chk_lfsr_r <= lfsr_next(chk_lfsr_r);
            end
            // Completion wins over timeout: a completing cycle carries a beat.
            if (complete_s) begin
                done_r <= 1'b1;
                pass_r <= (err_cnt_nx_s == 16'h0000);
            end else if (timeout_s) begin
                done_r    <= 1'b1;
                pass_r    <= 1'b0;
                timeout_r <= 1'b1;
            end
        end
    end

`ifdef AXIS_TRAFFIC_BACKPRESSURE_EN
    // Throttle LFSR and write-side gap flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_lfsr_r <= BP_SEED;
            gap_r     <= 1'b0;
        end else if (start_acc_s) begin
            bp_lfsr_r <= BP_SEED;
            gap_r     <= 1'b0;
        end else if (state_r == ST_RUN) begin
            bp_lfsr_r <= lfsr_next(bp_lfsr_r);
            gap_r     <= wr_beat_s && bp_lfsr_r[1];
        end else begin
            gap_r     <= 1'b0;
        end
    end
`endif

    // Output decode; every output depends only on registered state.
    always_comb begin
        busy          = (state_r == ST_RUN);
        m_axis_tvaild = m_vld_s;
        m_axis_tdata  = gen_lfsr_r;
        s_axis_tready = s_rdy_s;
        done          = done_r;
        pass          = pass_r;
        timeout       = timeout_r;
        err_cnt       = err_cnt_r;
        first_err_idx = first_err_idx_r;
        wr_cnt        = wr_cnt_r;
        rd_cnt        = rd_cnt_r;
    end

endmodule

// File: tb/tb_axis_fifo_traffic_gen_chk.sv
// -----------------------------------------------------------------------------
// tb_axis_fifo_traffic_gen_chk
//
// Directed bench for axis_fifo_traffic_gen_chk. A queue-based loopback stands
// in for the FIFO controller: accepted write words are queued (optionally with
// one word corrupted) and presented back on the read stream.
// -----------------------------------------------------------------------------
module tb_axis_fifo_traffic_gen_chk;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] num_words;
    logic        m_axis_tvaild;
    logic        m_axis_tready;
    logic [15:0] m_axis_tdata;
    logic        s_axis_tvaild;
    logic        s_axis_tready;
    logic [15:0] s_axis_tdata;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] err_cnt;
    logic [31:0] first_err_idx;
    logic [31:0] wr_cnt;
    logic [31:0] rd_cnt;

    int          errors = 0;
    int          checks = 0;

    logic [15:0] q[$];
    int          wr_idx = 0;
    int          corrupt_idx = -1;
    logic        block_rd = 1'b0;
    logic        hold_wr = 1'b0;
    logic        wbeat;
    logic        rbeat;
    logic [15:0] wdata;
    logic [15:0] exp_w = 16'hACE1;

    always #5 clk = ~clk;

    axis_fifo_traffic_gen_chk #(
        .SEED           (16'hACE1),
        .CNT_W          (32),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .num_words     (num_words),
        .m_axis_tvaild (m_axis_tvaild),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .s_axis_tvaild (s_axis_tvaild),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx),
        .wr_cnt        (wr_cnt),
        .rd_cnt        (rd_cnt)
    );

    function automatic logic [15:0] tb_lfsr(input logic [15:0] c);
        logic fb;
        fb = c[15] ^ c[13] ^ c[12] ^ c[10];
        return {c[14:0], fb};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive loopback at negedge, observe beats, update model after posedge.
    task automatic cycle();
        @(negedge clk);
        if ((q.size() > 0) && !block_rd) begin
            s_axis_tvaild = 1'b1;
            s_axis_tdata  = q[0];
        end else begin
            s_axis_tvaild = 1'b0;
            s_axis_tdata  = 16'h0000;
        end
        m_axis_tready = !hold_wr;
        #1;
        wbeat = m_axis_tvaild & m_axis_tready;
        rbeat = s_axis_tvaild & s_axis_tready;
        wdata = m_axis_tdata;
        if (wbeat) chk("wr_data_order", {16'h0, wdata}, {16'h0, exp_w});
        @(posedge clk);
        #1;
        if (rbeat) void'(q.pop_front());
        if (wbeat) begin
            q.push_back((wr_idx == corrupt_idx) ? (wdata ^ 16'h0001) : wdata);
            wr_idx++;
            exp_w = tb_lfsr(exp_w);
        end
    endtask

    task automatic start_test(input logic [31:0] n);
        q.delete();
        wr_idx    = 0;
        exp_w     = 16'hACE1;
        start     = 1'b1;
        num_words = n;
        cycle();
        start     = 1'b0;
    endtask

    task automatic run_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) break;
            cycle();
        end
        chk("done_reached", {31'h0, done}, 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"},    {31'h0, busy},          32'd0);
        chk({tag, "_done"},    {31'h0, done},          32'd0);
        chk({tag, "_pass"},    {31'h0, pass},          32'd0);
        chk({tag, "_timeout"}, {31'h0, timeout},       32'd0);
        chk({tag, "_err"},     {16'h0, err_cnt},       32'd0);
        chk({tag, "_first"},   first_err_idx,          32'hFFFF_FFFF);
        chk({tag, "_wr"},      wr_cnt,                 32'd0);
        chk({tag, "_rd"},      rd_cnt,                 32'd0);
        chk({tag, "_tvalid"},  {31'h0, m_axis_tvaild}, 32'd0);
        chk({tag, "_tready"},  {31'h0, s_axis_tready}, 32'd0);
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        num_words     = 32'd0;
        m_axis_tready = 1'b1;
        s_axis_tvaild = 1'b0;
        s_axis_tdata  = 16'h0000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("post_rst");

        // Single word: first word visible the cycle after start
        start_test(32'd1);
        chk("n1_tvalid", {31'h0, m_axis_tvaild}, 32'd1);
        chk("n1_tdata",  {16'h0, m_axis_tdata},  32'h0000_ACE1);
        chk("n1_busy",   {31'h0, busy},          32'd1);
        run_done(20);
        chk("n1_pass",   {31'h0, pass},          32'd1);
        chk("n1_err",    {16'h0, err_cnt},       32'd0);
        chk("n1_wr",     wr_cnt,                 32'd1);
        chk("n1_rd",     rd_cnt,                 32'd1);
        chk("n1_busy_end", {31'h0, busy},        32'd0);
        chk("n1_tvalid_end", {31'h0, m_axis_tvaild}, 32'd0);
        chk("n1_tready_end", {31'h0, s_axis_tready}, 32'd0);

        // 512 words: second word 16'h59C3
        start_test(32'd512);
        cycle();
        chk("n512_word2", {16'h0, m_axis_tdata}, 32'h0000_59C3);
        run_done(2000);
        chk("n512_pass", {31'h0, pass},    32'd1);
        chk("n512_wr",   wr_cnt,           32'd512);
        chk("n512_rd",   rd_cnt,           32'd512);
        chk("n512_err",  {16'h0, err_cnt}, 32'd0);

        // 4 words with read word 2 corrupted
        corrupt_idx = 2;
        start_test(32'd4);
        run_done(50);
        corrupt_idx = -1;
        chk("corr_err",   {16'h0, err_cnt}, 32'd1);
        chk("corr_first", first_err_idx,    32'd2);
        chk("corr_pass",  {31'h0, pass},    32'd0);
        chk("corr_rd",    rd_cnt,           32'd4);

        // 8 words with write ready held low for 5 cycles mid-stream
        start_test(32'd8);
        cycle();
        cycle();
        cycle();
        hold_wr = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("hold_tvalid", {31'h0, m_axis_tvaild}, 32'd1);
            chk("hold_tdata",  {16'h0, m_axis_tdata},  {16'h0, exp_w});
            chk("hold_wr_cnt", wr_cnt,                 32'd3);
        end
        hold_wr = 1'b0;
        run_done(100);
        chk("hold_pass", {31'h0, pass},    32'd1);
        chk("hold_wr",   wr_cnt,           32'd8);
        chk("hold_rd",   rd_cnt,           32'd8);
        chk("hold_err",  {16'h0, err_cnt}, 32'd0);

        // Timeout: read stream never valid
        block_rd = 1'b1;
        start_test(32'd4);
        run_done(400);
        block_rd = 1'b0;
        chk("to_timeout", {31'h0, timeout}, 32'd1);
        chk("to_pass",    {31'h0, pass},    32'd0);
        chk("to_rd",      rd_cnt,           32'd0);
        chk("to_wr",      wr_cnt,           32'd4);
        chk("to_busy",    {31'h0, busy},    32'd0);

        // Zero-length test completes on the next edge
        start_test(32'd0);
        chk("n0_done",    {31'h0, done},          32'd1);
        chk("n0_pass",    {31'h0, pass},          32'd1);
        chk("n0_busy",    {31'h0, busy},          32'd0);
        chk("n0_timeout", {31'h0, timeout},       32'd0);
        chk("n0_wr",      wr_cnt,                 32'd0);
        chk("n0_tvalid",  {31'h0, m_axis_tvaild}, 32'd0);

        // Reset asserted mid-run
        start_test(32'd8);
        cycle();
        cycle();
        chk("mid_busy", {31'h0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;

        // Restart after reset: LFSR reloaded
        @(posedge clk);
        #1;
        start_test(32'd2);
        chk("restart_tdata", {16'h0, m_axis_tdata}, 32'h0000_ACE1);
        run_done(20);
        chk("restart_pass", {31'h0, pass}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
